// File: rtl/byte_unstrip.sv
// Lane-to-byte merger: takes a LANES-wide word and replays its lanes one byte
// per cycle, lane 0 first. It also tracks the packet framing symbols and pulses
// ERR on any byte that breaks the framing rules.
module byte_unstrip #(
  parameter int unsigned LANES = 4,
  parameter int unsigned BITS  = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_L,
  input  logic [BITS*LANES-1:0] LANE,
  input  logic [LANES-1:0]      LANE_DK,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [BITS-1:0]       D,
  output logic                  o_DK,
  output logic                  VALID,
  output logic                  ERR
);

  localparam int unsigned IdxW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(LANES - 1);

  // Framing symbol codes. They only count as codes when the byte's control
  // flag is set.
  localparam logic [BITS-1:0] SymStp = BITS'(8'hFB);
  localparam logic [BITS-1:0] SymSdp = BITS'(8'h5C);
  localparam logic [BITS-1:0] SymEnd = BITS'(8'hFD);
  localparam logic [BITS-1:0] SymEdb = BITS'(8'hFE);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e                  state_q, state_d;
  logic [BITS*LANES-1:0]   word_q;
  logic [LANES-1:0]        word_dk_q;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [BITS-1:0]         d_q;
  logic                    dk_q;
  logic                    err_q, err_d;
  logic                    in_pkt_q, in_pkt_d;

  logic                    accept;
  logic                    at_last;
  logic                    load;
  logic [BITS-1:0]         sel_byte;
  logic                    sel_dk;
  logic                    is_start;
  logic                    is_end;

  assign at_last = (idx_q == LastIdx);
  assign accept  = IN_VALID & IN_READY;

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: leave SHIFT only when the last lane goes out with nothing new.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StShift;
      StShift: if (at_last && !accept) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; READY lets a new word in on the same edge the last lane leaves.
  always_comb begin
    VALID    = (state_q == StShift);
    IN_READY = (state_q == StIdle) || at_last;
  end

  // Pick the byte to show next cycle: lane 0 of a new word, or the next stored lane.
  always_comb begin
    load     = 1'b0;
    sel_byte = '0;
    sel_dk   = 1'b0;
    idx_d    = idx_q;
    if (accept) begin
      load     = 1'b1;
      sel_byte = LANE[BITS-1:0];
      sel_dk   = LANE_DK[0];
      idx_d    = '0;
    end else if (state_q == StShift && !at_last) begin
      load     = 1'b1;
      sel_byte = word_q[BITS*(int'(idx_q) + 1) +: BITS];
      sel_dk   = word_dk_q[int'(idx_q) + 1];
      idx_d    = idx_q + IdxW'(1);
    end
  end

  // Framing check on the incoming byte; the packet flag follows the symbol
  // even when it is in error so the tracker resynchronises on it.
  always_comb begin
    is_start = sel_dk && (sel_byte == SymStp || sel_byte == SymSdp);
    is_end   = sel_dk && (sel_byte == SymEnd || sel_byte == SymEdb);
    err_d    = load && ((is_start && (idx_d != '0 || in_pkt_q)) ||
                        (is_end && (idx_d != LastIdx || !in_pkt_q)));
    in_pkt_d = in_pkt_q;
    if (load && is_start) begin
      in_pkt_d = 1'b1;
    end else if (load && is_end) begin
      in_pkt_d = 1'b0;
    end
  end

  // Word store, output byte, lane index and framing state.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      word_q    <= '0;
      word_dk_q <= '0;
      idx_q     <= '0;
      d_q       <= '0;
      dk_q      <= 1'b0;
      err_q     <= 1'b0;
      in_pkt_q  <= 1'b0;
    end else begin
      if (accept) begin
        word_q    <= LANE;
        word_dk_q <= LANE_DK;
      end
      if (load) begin
        d_q  <= sel_byte;
        dk_q <= sel_dk;
      end
      idx_q    <= idx_d;
      err_q    <= err_d;
      in_pkt_q <= in_pkt_d;
    end
  end

  assign D    = d_q;
  assign o_DK = dk_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_byte_unstrip.sv
// Directed bench for byte_unstrip (LANES=4, BITS=8) with a byte scoreboard.
module tb_byte_unstrip;

  logic        CLK = 1'b0;
  logic        RESET_L = 1'b0;
  logic [31:0] LANE = '0;
  logic [3:0]  LANE_DK = '0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [7:0]  D;
  logic        o_DK;
  logic        VALID;
  logic        ERR;

  int errors = 0;
  int checks = 0;

  // Expected byte stream: {data, dk, err}.
  logic [9:0] sb[$];
  bit         model_pkt = 0;
  bit         in_reset = 1;

  byte_unstrip #(.LANES(4), .BITS(8)) dut (
    .CLK      (CLK),
    .RESET_L  (RESET_L),
    .LANE     (LANE),
    .LANE_DK  (LANE_DK),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .D        (D),
    .o_DK     (o_DK),
    .VALID    (VALID),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference framing model applied in output order.
  task automatic push_word(input logic [31:0] w, input logic [3:0] k);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      bit st, en, e;
      b  = w[8*i +: 8];
      st = k[i] && (b == 8'hFB || b == 8'h5C);
      en = k[i] && (b == 8'hFD || b == 8'hFE);
      e  = (st && (i != 0 || model_pkt)) || (en && (i != 3 || !model_pkt));
      if (st) model_pkt = 1;
      else if (en) model_pkt = 0;
      sb.push_back({b, k[i], e});
    end
  endtask

  task automatic send(input logic [31:0] w, input logic [3:0] k, output int stalls);
    stalls = 0;
    @(negedge CLK);
    LANE = w;
    LANE_DK = k;
    IN_VALID = 1'b1;
    while (!IN_READY && stalls < 20) begin
      stalls++;
      @(negedge CLK);
    end
    if (!IN_READY) begin
      check("accept_timeout", 32'(IN_READY), 32'd1);
    end else begin
      push_word(w, k);
      @(posedge CLK);
    end
  endtask

  task automatic go_idle();
    @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge CLK);
      n++;
    end
    @(posedge CLK);
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
    check("idle_valid", 32'(VALID), 32'd0);
  endtask

  // Output monitor: sampled 1 time unit after each rising edge.
  always @(posedge CLK) begin
    #1;
    if (!in_reset) begin
      if (VALID) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          logic [9:0] e;
          e = sb.pop_front();
          check("byte_d", 32'(D), 32'(e[9:2]));
          check("byte_dk", 32'(o_DK), 32'(e[1]));
          check("byte_err", 32'(ERR), 32'(e[0]));
        end
      end else begin
        check("err_when_idle", 32'(ERR), 32'd0);
        check("no_gap", 32'(sb.size()), 32'd0);
      end
    end
  end

  initial begin
    int st;
    // Reset state.
    #12;
    check("rst_d", 32'(D), 32'd0);
    check("rst_dk", 32'(o_DK), 32'd0);
    check("rst_valid", 32'(VALID), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_ready", 32'(IN_READY), 32'd1);
    @(negedge CLK);
    RESET_L = 1'b1;
    in_reset = 0;

    // Well-framed packet in one word: STP .. END.
    send(32'hFD2211FB, 4'b1001, st);
    check("first_no_stall", 32'(st), 32'd0);
    go_idle();
    drain();

    // END in lane 3 outside a packet is an error; the same byte as data is not.
    send(32'hFD000000, 4'b1000, st);
    go_idle();
    drain();
    send(32'hFD000000, 4'b0000, st);
    go_idle();
    drain();

    // STP in lane 2: misplaced start, packet flag still set afterwards.
    send(32'h00FB0000, 4'b0100, st);
    go_idle();
    drain();
    // Packet open now, so a well-placed EDB closes it cleanly.
    send(32'hFE000000, 4'b1000, st);
    go_idle();
    drain();

    // Back-to-back words with IN_VALID held: three stall cycles, no bubble.
    send(32'h3344555C, 4'b0001, st);
    send(32'hFE776655, 4'b1000, st);
    check("b2b_stalls", 32'(st), 32'd3);
    go_idle();
    drain();

    // Start symbol while a packet is already open.
    send(32'h000000FB, 4'b0001, st);
    send(32'h000000FB, 4'b0001, st);
    go_idle();
    drain();

    // Random data words (no control flags): never an error.
    for (int i = 0; i < 4; i++) begin
      send($urandom, 4'b0000, st);
    end
    go_idle();
    drain();

    // Reset in the middle of a word at IDX=1.
    send(32'hFD2211FB, 4'b1001, st);
    go_idle();
    @(posedge CLK);
    #2;
    in_reset = 1;
    RESET_L = 1'b0;
    #1;
    check("mid_rst_valid", 32'(VALID), 32'd0);
    check("mid_rst_d", 32'(D), 32'd0);
    check("mid_rst_err", 32'(ERR), 32'd0);
    check("mid_rst_ready", 32'(IN_READY), 32'd1);
    sb.delete();
    model_pkt = 0;
    @(negedge CLK);
    RESET_L = 1'b1;
    in_reset = 0;
    check("post_rst_ready", 32'(IN_READY), 32'd1);
    repeat (6) @(posedge CLK);
    #1;
    check("post_rst_valid", 32'(VALID), 32'd0);

    // Framing state cleared by reset: a fresh STP..END is clean.
    send(32'hFD2211FB, 4'b1001, st);
    go_idle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/byte_unstrip.md
BYTE_UNSTRIP -- requirements
Module: byte_unstrip

Interface
REQ-001 Parameter LANES, default 4, number of lanes merged back into one byte stream (2..8).
REQ-002 Parameter BITS, default 8, byte width per lane.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RESET_L  input  1  asynchronous, active-low reset.
REQ-005 LANE  input  BITS*LANES  lane word; lane i occupies bits [BITS*i +: BITS].
REQ-006 LANE_DK  input  LANES  per-lane control flag; bit i = 1 marks lane i as a control symbol.
REQ-007 IN_VALID  input  1  LANE/LANE_DK hold a valid word.
REQ-008 IN_READY  output  1  block accepts a word this cycle.
REQ-009 D  output  BITS  reassembled byte.
REQ-010 o_DK  output  1  control flag of the byte on D.
REQ-011 VALID  output  1  D/o_DK hold a valid byte.
REQ-012 ERR  output  1  one-cycle framing-error pulse.

Function
REQ-013 The block SHALL accept a word on a posedge where IN_VALID=1 and IN_READY=1; otherwise it SHALL ignore LANE, LANE_DK and IN_VALID.
REQ-014 IN_READY SHALL be combinational: 1 when VALID=0, or when IDX=LANES-1; 0 otherwise.
REQ-015 IDX SHALL be an internal counter, 0..LANES-1, giving the lane index of the byte on D.
REQ-016 On accept, the block SHALL store the word, drive D=lane 0, o_DK=LANE_DK[0], VALID=1 and IDX=0 from the next cycle onward (latency 1 cycle).
REQ-017 While VALID=1 and IDX<LANES-1, each posedge SHALL advance IDX by 1 and drive D/o_DK from stored lane IDX+1.
REQ-018 At IDX=LANES-1 with an accept, lane 0 of the new word SHALL follow on the next cycle with no bubble.
REQ-019 At IDX=LANES-1 without an accept, VALID SHALL go 0, and D and o_DK SHALL hold their last values.
REQ-020 States: IDLE (VALID=0) and SHIFT (VALID=1); IDLE->SHIFT on accept; SHIFT->IDLE at IDX=LANES-1 with no accept.
REQ-021 Symbol codes: STP=0xFB, SDP=0x5C, END=0xFD, EDB=0xFE. A byte counts as a code only when its control flag is 1.
REQ-022 The IN_PKT flag SHALL set when STP/SDP is output and clear when END/EDB is output.
REQ-023 ERR SHALL be 1 in the same cycle as the offending byte on D for any of:
 - STP/SDP at IDX!=0;
 - END/EDB at IDX!=LANES-1;
 - STP/SDP while IN_PKT=1;
 - END/EDB while IN_PKT=0.
REQ-024 On any error, the IN_PKT update SHALL still apply, so the block resynchronises on the erroneous symbol.
REQ-025 Bytes with the control flag 0 SHALL never raise ERR or change IN_PKT.
REQ-026 ERR SHALL be 0 whenever VALID=0.

Reset
REQ-027 While RESET_L=0, and immediately on its assertion: D=0, o_DK=0, VALID=0, ERR=0, IDX=0, IN_PKT=0, stored word=0, state IDLE; IN_READY=1 follows.
REQ-028 Reset asserted mid-word SHALL discard the remaining stored bytes; no partial byte SHALL appear after release.
REQ-029 The first accept SHALL occur no earlier than the first posedge with RESET_L=1.

Verification
REQ-030 LANES=4, word {l3..l0}={FD,22,11,FB}, LANE_DK=1001, IN_VALID for 1 cycle -> D=FB,11,22,FD on 4 consecutive cycles, VALID=1, ERR=0, IN_PKT 1 then 0; then VALID=0.
REQ-031 Two words presented back-to-back with IN_VALID held high -> IN_READY=0 for 3 cycles, 8 bytes output with no VALID gap, second word accepted on the IDX=3 edge.
REQ-032 Word {00,FB,00,00}, LANE_DK=0100 -> ERR=1 only in the cycle D=FB (IDX=2), IN_PKT=1 afterwards.
REQ-033 END (0xFD, DK=1) in lane 3 with IN_PKT=0 -> ERR pulse on that byte; same byte with DK=0 -> ERR=0.
REQ-034 RESET_L pulled low while IDX=1 -> VALID, D and ERR go to 0 asynchronously; after release, IN_READY=1 and no stale byte is output.
